// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if
// Bundles every EX->MEM signal of the ex_mem_pipe stage: the upstream beat
// from EX, the downstream beat to MEM, flush, and the branch redirect to fetch.
//   slave  : used by ex_mem_pipe (consumes in_*, flush, out_ready;
//            drives in_ready, out_*, branch_taken, branch_target)
//   master : used by the surrounding pipeline (the opposite directions)
// Optional macro EX_MEM_PERF_CNT_EN adds the stall_cycles counter output.
interface ex_mem_pipe_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_zero;
   logic [DATA_W-1:0] in_store_data;
   logic [RD_W-1:0]   in_rd;
   logic              in_branch;
   logic [DATA_W-1:0] in_branch_target;
   logic              in_mem_read;
   logic              in_mem_write;
   logic              in_reg_write;
   logic              in_mem_to_reg;
   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [DATA_W-1:0] out_store_data;
   logic [RD_W-1:0]   out_rd;
   logic              out_mem_read;
   logic              out_mem_write;
   logic              out_reg_write;
   logic              out_mem_to_reg;

   logic              branch_taken;
   logic [DATA_W-1:0] branch_target;
`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0]       stall_cycles;
`endif

   modport slave (
      input  in_valid, in_result, in_zero, in_store_data, in_rd, in_branch,
             in_branch_target, in_mem_read, in_mem_write, in_reg_write,
             in_mem_to_reg, flush, out_ready,
      output in_ready, out_valid, out_result, out_store_data, out_rd,
             out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
             branch_taken, branch_target
`ifdef EX_MEM_PERF_CNT_EN
      , output stall_cycles
`endif
   );

   modport master (
      output in_valid, in_result, in_zero, in_store_data, in_rd, in_branch,
             in_branch_target, in_mem_read, in_mem_write, in_reg_write,
             in_mem_to_reg, flush, out_ready,
      input  in_ready, out_valid, out_result, out_store_data, out_rd,
             out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
             branch_taken, branch_target
`ifdef EX_MEM_PERF_CNT_EN
      , input stall_cycles
`endif
   );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
// EX/MEM pipeline register built as a 2-entry skid buffer (main + skid entry).
// The main entry drives the MEM-side outputs. Taken branches (branch & zero)
// are resolved when the beat is accepted and produce a registered one-cycle
// redirect pulse with its target.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ex_mem_pipe_if.slave (EX beat in, MEM beat out, flush, redirect)
// Optional macro EX_MEM_PERF_CNT_EN adds a saturating stall_cycles counter
// (out_valid & ~out_ready edges), cleared only by rst_n.
module ex_mem_pipe #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input logic          clk,
   input logic          rst_n,
   ex_mem_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
      logic [RD_W-1:0]   rd;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              mem_to_reg;
   } beat_t;

   state_t            state;
   beat_t             main_q;
   beat_t             skid_q;
   beat_t             in_beat;
   logic              accept;
   logic              pop;
   logic              take;
   logic              branch_taken_q;
   logic [DATA_W-1:0] branch_target_q;

   // Handshake and branch resolution; ready and valid come straight from the
   // state register so nothing downstream reaches upstream combinationally.
   assign bus.in_ready  = (state != TWO);
   assign bus.out_valid = (state != EMPTY);
   assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
   assign pop           = bus.out_valid & bus.out_ready;
   assign take          = accept & bus.in_branch & bus.in_zero;

   assign in_beat = '{
      result:     bus.in_result,
      store_data: bus.in_store_data,
      rd:         bus.in_rd,
      mem_read:   bus.in_mem_read,
      mem_write:  bus.in_mem_write,
      reg_write:  bus.in_reg_write,
      mem_to_reg: bus.in_mem_to_reg
   };

   // Occupancy FSM plus storage. Flush only empties the state; data fields
   // keep their last value since consumers look at out_valid alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (bus.flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q <= in_beat;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_q <= in_beat;
               end else if (accept) begin
                  skid_q <= in_beat;
                  state  <= TWO;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Redirect pulse: one cycle per taken branch accepted, independent of
   // whether MEM is stalling. The target holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
      end else begin
         branch_taken_q <= take;
         if (take) begin
            branch_target_q <= bus.in_branch_target;
         end
      end
   end

   assign bus.out_result     = main_q.result;
   assign bus.out_store_data = main_q.store_data;
   assign bus.out_rd         = main_q.rd;
   assign bus.out_mem_read   = main_q.mem_read;
   assign bus.out_mem_write  = main_q.mem_write;
   assign bus.out_reg_write  = main_q.reg_write;
   assign bus.out_mem_to_reg = main_q.mem_to_reg;
   assign bus.branch_taken   = branch_taken_q;
   assign bus.branch_target  = branch_target_q;

`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0] stall_cnt;

   // Counts edges where MEM holds off a valid beat; sticks at all-ones and
   // survives flush so it reflects the whole run since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Pipeline stage directly downstream of the ALU. It captures the ALU result, branch flag, store data, destination register and memory/writeback control bits.
- Presents the captured beat to the MEM stage through a 2-entry skid buffer with valid/ready handshake.
- Resolves branches at acceptance: an accepted beat with branch=1 and zero=1 produces a registered one-cycle redirect pulse to fetch.
- Flush input discards all buffered beats.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
RD_W, 5, width of destination register index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  EX beat valid
in_ready  output  1  stage can accept a beat; equals ~skid_valid (registered, no comb path from out_ready)
in_result  input  DATA_W  ALU result (address for loads/stores)
in_zero  input  1  ALU branch flag: 1 = branch condition true (BEQ equal / BNE not equal)
in_store_data  input  DATA_W  rs2 value for stores
in_rd  input  RD_W  destination register
in_branch  input  1  beat is a conditional branch
in_branch_target  input  DATA_W  precomputed branch target PC
in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg  input  1 each  control bits
flush  input  1  synchronous discard of all buffered beats
out_valid  output  1  MEM beat valid
out_ready  input  1  MEM stage accepts
out_result, out_store_data  output  DATA_W  captured fields
out_rd  output  RD_W  captured field
out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  output  1 each  captured control
branch_taken  output  1  one-cycle redirect pulse
branch_target  output  DATA_W  redirect PC, valid while branch_taken=1

Behaviour:
- Handshakes:
  - accept = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - Storage is a main entry (drives outputs) and a skid entry.
- States by occupancy:
  - EMPTY (main empty, skid empty).
  - ONE (main full, skid empty).
  - TWO (both full; in_ready=0).
- Transitions per edge, flush=0:
  - EMPTY: accept -> ONE, beat loads main.
  - ONE: accept & pop -> ONE, main reloaded with new beat. accept & ~pop -> TWO, beat loads skid. ~accept & pop -> EMPTY. Otherwise hold.
  - TWO: pop -> ONE, skid moves to main. No accept is possible in this state.
- Flush: next edge -> EMPTY regardless of accept/pop. Flush overrides a simultaneous accept: the beat is dropped, and no branch_taken is raised for it.
- Data fields hold their last value while out_valid=0. Only the valid bits gate consumers.
- Branch resolution:
  - On an edge with accept & in_branch & in_zero: branch_taken=1 for exactly the next cycle, and branch_target<=in_branch_target.
  - Otherwise branch_taken<=0 and branch_target holds.
  - Resolution is independent of downstream stall. The branch beat itself is still buffered and forwarded (control bits normally 0).
- Back-to-back taken branches on consecutive accepts give consecutive pulses with the updated target.
- Latency: 1 cycle from accept to out_valid when EMPTY. No combinational in->out path.
- Reset (rst_n=0, asynchronous) -> EMPTY, out_valid=0, in_ready=1, branch_taken=0. All data outputs, branch_target and control outputs are 0.
- Reset asserted mid-operation discards buffered beats immediately. The first accept is possible on the first edge after deassertion.
- Ordering: beats leave in acceptance order. No beat is lost or duplicated except by flush/reset.

Optional Feature:
- Macro EX_MEM_PERF_CNT_EN.
- Defined: adds output port stall_cycles [31:0].
  - Increments on every edge where out_valid & ~out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst_n only; flush does not clear it.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset -> out_valid=0, in_ready=1, branch_taken=0, all outputs 0. Assert rst_n=0 while in TWO -> outputs clear immediately, without waiting for a clock edge.
- out_ready=1, stream results 0x10,0x20,0x30 with rd 1,2,3 on consecutive cycles -> identical sequence on outputs, each 1 cycle later, in_ready stays 1.
- out_ready=0, send 0xA then 0xB -> state TWO, in_ready=0, out_result=0xA. Raise out_ready -> 0xA then 0xB pop in order, in_ready returns to 1.
- Accept beat with in_branch=1, in_zero=1, target 0x0000_0400 while out_ready=0 -> branch_taken=1 for one cycle, branch_target=0x400. Same beat with in_zero=0 -> no pulse.
- State TWO, flush=1 together with in_valid -> next cycle EMPTY, out_valid=0, new beat dropped, no branch_taken even if that beat was a taken branch.
- With EX_MEM_PERF_CNT_EN: hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cycles=5. Preload near max -> saturates at 0xFFFF_FFFF.
